fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + load-use hazard unit for the pipelined MIPS core. Tracks destination

---
 rtl/fwd_pkg.sv | 30 +++
 rtl/fwd_src_match.sv | 51 +++++
 rtl/fwd_hazard_unit.sv | 95 +++++++++
 tb/tb_fwd_hazard_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared constants and tag type for the forwarding / load-use
//                hazard unit (stage indices, regfile select code, tag layout).
//  Revision    : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // Register number width of the MIPS core
    localparam int REG_AW      = 5;

    // Select code meaning "take operand from the register file"
    localparam int FWD_REGFILE = 0;

    // Stage indices of the tag pipeline (1 = youngest)
    localparam int EX  = 1;
    localparam int MEM = 2;
    localparam int WB  = 3;

    // Destination tag carried by every in-flight instruction
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              is_load;
    } fwd_tag_t;

endpackage
`default_nettype wire

// File: rtl/fwd_src_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_src_match
//  Description : Priority encoder for one decode source operand. Scans the
//                tracked stage tags and returns the youngest producing stage
//                plus whether that producer is a load whose data is not ready.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int AW         = REG_AW,
    parameter int SW         = 2,
    parameter int LOAD_READY = MEM
) (
    input  logic [AW-1:0]             src_addr_i,
    input  logic                      src_used_i,
    input  logic [DEPTH-1:0]          tag_valid_i,
    input  logic [DEPTH-1:0][AW-1:0]  tag_dst_i,
    input  logic [DEPTH-1:0]          tag_regwrite_i,
    input  logic [DEPTH-1:0]          tag_load_i,
    output logic [SW-1:0]             sel_o,
    output logic                      load_hazard_o
);

    logic [DEPTH-1:0] w_hit;

    // Per-stage hit: live writer of the same, non-zero register actually read
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_hit[k] = src_used_i && tag_valid_i[k] && tag_regwrite_i[k] &&
                       (tag_dst_i[k] == src_addr_i) && (tag_dst_i[k] != '0);
        end
    end

    // Oldest-to-youngest scan so the youngest hit overwrites and wins
    always_comb begin
        sel_o         = SW'(FWD_REGFILE);
        load_hazard_o = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_hit[k-1]) begin
                sel_o         = SW'(k);
                load_hazard_o = tag_load_i[k-1] && (k < LOAD_READY);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Forwarding select and load-use stall generation for the
//                pipelined MIPS core. Keeps a DEPTH-stage pipeline of
//                destination tags beside ID; one matcher per source operand.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int AW         = REG_AW,
    parameter int LOAD_READY = MEM,
    parameter int SW         = $clog2(DEPTH+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC*AW-1:0]   src_addr_i,
    input  logic [NUM_SRC-1:0]      src_used_i,
    input  logic                    id_valid_i,
    input  logic [AW-1:0]           id_dst_i,
    input  logic                    id_regwrite_i,
    input  logic                    id_memread_i,
    input  logic                    flush_i,
    output logic [NUM_SRC*SW-1:0]   fwd_sel_o,
    output logic                    stall_o
);

    // Tag pipeline, index k-1 holds stage k
    logic [DEPTH-1:0]         valid_q,    valid_d;
    logic [DEPTH-1:0][AW-1:0] dst_q,      dst_d;
    logic [DEPTH-1:0]         regwrite_q, regwrite_d;
    logic [DEPTH-1:0]         load_q,     load_d;

    logic [NUM_SRC-1:0]       w_hazard;
    logic                     w_issue;

    // One independent matcher per decode source operand
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_match #(
                .DEPTH      (DEPTH),
                .AW         (AW),
                .SW         (SW),
                .LOAD_READY (LOAD_READY)
            ) u_match (
                .src_addr_i     (src_addr_i[i*AW +: AW]),
                .src_used_i     (src_used_i[i]),
                .tag_valid_i    (valid_q),
                .tag_dst_i      (dst_q),
                .tag_regwrite_i (regwrite_q),
                .tag_load_i     (load_q),
                .sel_o          (fwd_sel_o[i*SW +: SW]),
                .load_hazard_o  (w_hazard[i])
            );
        end
    endgenerate

    // Flush kills the decode instruction, so it can never be the one stalling
    assign stall_o = id_valid_i && !flush_i && (|w_hazard);
    assign w_issue = id_valid_i && !stall_o && !flush_i;

    // Stages always advance; stage 1 gets the decode tag or a bubble
    always_comb begin
        for (int k = DEPTH-1; k >= 1; k--) begin
            valid_d[k]    = valid_q[k-1];
            dst_d[k]      = dst_q[k-1];
            regwrite_d[k] = regwrite_q[k-1];
            load_d[k]     = load_q[k-1];
        end
        valid_d[EX-1]    = w_issue;
        dst_d[EX-1]      = w_issue ? id_dst_i : '0;
        regwrite_d[EX-1] = w_issue && id_regwrite_i;
        load_d[EX-1]     = w_issue && id_memread_i;
    end

    // Tag register array; reset discards every in-flight tag
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            dst_q      <= '0;
            regwrite_q <= '0;
            load_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            dst_q      <= dst_d;
            regwrite_q <= regwrite_d;
            load_q     <= load_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Randomized self-checking bench for fwd_hazard_unit against a
//                history-based reference of recently issued instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int NUM_SRC    = 2;
    localparam int DEPTH      = 3;
    localparam int AW         = 5;
    localparam int LOAD_READY = 2;
    localparam int SW         = 2;
    localparam int N_CYCLES   = 4000;

    logic                  clk;
    logic                  rst;
    logic [NUM_SRC*AW-1:0] src_addr_i;
    logic [NUM_SRC-1:0]    src_used_i;
    logic                  id_valid_i;
    logic [AW-1:0]         id_dst_i;
    logic                  id_regwrite_i;
    logic                  id_memread_i;
    logic                  flush_i;
    logic [NUM_SRC*SW-1:0] fwd_sel_o;
    logic                  stall_o;

    int total;
    int bad;

    fwd_hazard_unit #(
        .NUM_SRC    (NUM_SRC),
        .DEPTH      (DEPTH),
        .AW         (AW),
        .LOAD_READY (LOAD_READY),
        .SW         (SW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .src_addr_i    (src_addr_i),
        .src_used_i    (src_used_i),
        .id_valid_i    (id_valid_i),
        .id_dst_i      (id_dst_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_sel_o     (fwd_sel_o),
        .stall_o       (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list of what issued in each of the last DEPTH cycles,
    // entry 0 = issued one cycle ago (its result is k cycles old at index k-1)
    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit ld;
    } ent_t;

    ent_t hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_hist();
        ent_t b;
        b.v = 0; b.dst = 0; b.rw = 0; b.ld = 0;
        hist = {};
        for (int k = 0; k < DEPTH; k++) hist.push_back(b);
    endtask

    initial begin
        bit   prev_rst;
        int   exp_sel [NUM_SRC];
        bit   exp_stall;
        bit   any_haz;
        int   a;
        ent_t ne;

        total = 0;
        bad   = 0;
        rst           = 1'b1;
        src_addr_i    = '0;
        src_used_i    = '0;
        id_valid_i    = 1'b0;
        id_dst_i      = '0;
        id_regwrite_i = 1'b0;
        id_memread_i  = 1'b0;
        flush_i       = 1'b0;
        clear_hist();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            prev_rst = rst;

            // Small register range keeps hits frequent; occasional wide values
            rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
                src_addr_i[i*AW +: AW] = AW'(a);
                src_used_i[i]          = ($urandom_range(0, 9) < 8);
            end
            id_valid_i    = ($urandom_range(0, 9) < 9);
            a             = $urandom_range(0, 3);
            id_dst_i      = AW'(a);
            id_regwrite_i = ($urandom_range(0, 9) < 8);
            id_memread_i  = ($urandom_range(0, 9) < 4);
            flush_i       = ($urandom_range(0, 9) == 0);
            #3;

            // Cycle following a sampled reset: nothing may be forwarded
            if (prev_rst) begin
                for (int i = 0; i < NUM_SRC; i++)
                    chk("post_reset_sel", 32'(fwd_sel_o[i*SW +: SW]), 32'd0);
                chk("post_reset_stall", 32'(stall_o), 32'd0);
            end

            // Youngest matching issued instruction supplies each operand
            any_haz = 0;
            for (int i = 0; i < NUM_SRC; i++) begin
                exp_sel[i] = 0;
                for (int k = 1; k <= DEPTH; k++) begin
                    if (exp_sel[i] == 0 && src_used_i[i] && hist[k-1].v && hist[k-1].rw &&
                        hist[k-1].dst != 0 && hist[k-1].dst == int'(src_addr_i[i*AW +: AW]))
                        exp_sel[i] = k;
                end
                if (exp_sel[i] != 0 && hist[exp_sel[i]-1].ld && exp_sel[i] < LOAD_READY)
                    any_haz = 1;
                chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel_o[i*SW +: SW]), 32'(exp_sel[i]));
            end
            exp_stall = id_valid_i && !flush_i && any_haz;
            chk("stall", 32'(stall_o), 32'(exp_stall));

            // Advance the reference for the coming edge
            if (rst) begin
                clear_hist();
            end else begin
                ne.v   = id_valid_i && !exp_stall && !flush_i;
                ne.dst = ne.v ? int'(id_dst_i) : 0;
                ne.rw  = ne.v && id_regwrite_i;
                ne.ld  = ne.v && id_memread_i;
                hist.push_front(ne);
                void'(hist.pop_back());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
